prog_loader: RTL and testbench

Program loader that sits directly upstream of the single-cycle core's instruction memory. It accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words. It writes those words into instruction memory from word 0 upward. The core is held in reset until the programmed word count has been written, then released.

---
 rtl/prog_loader_pkg.sv | 15 +
 rtl/word_packer.sv | 37 +++
 rtl/prog_loader.sv | 113 +++++++++++
 tb/tb_prog_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Included by the loader top and its byte-packing sub-module.
package prog_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } loader_state_e;

endpackage

// File: rtl/word_packer.sv
// Packs an accepted byte stream little-endian into one 32-bit word.
// Byte n of the word lands in bits [8n+7:8n]; o_last_byte flags byte 3.
module word_packer
  import prog_loader_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_accept,
  input  logic              i_clear,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [DW-1:0]     o_word,
  output logic              o_last_byte
);

  logic [1:0]    r_byte_cnt;
  logic [DW-1:0] r_word;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byte_cnt <= '0;
      r_word     <= '0;
    end else if (i_clear) begin
      r_byte_cnt <= '0;
    end else if (i_accept) begin
      r_word[{r_byte_cnt, 3'b000} +: BYTE_W] <= i_byte;
      r_byte_cnt                             <= r_byte_cnt + 2'd1;
    end
  end

  assign o_word      = r_word;
  assign o_last_byte = (r_byte_cnt == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Streams bytes into instruction memory as words starting at word 0, holding
// the core in reset until the requested word count has been written.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DW             = 32,
  parameter int MEM_SIZE_IN_KB = 1,
  parameter int NO_OF_REGS     = MEM_SIZE_IN_KB * 1024 / 4,
  parameter int AW             = $clog2(NO_OF_REGS) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [AW-1:0] len_words_i,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_data_i,
  output logic          byte_ready_o,
  output logic          imem_we_o,
  output logic [DW-1:0] imem_addr_o,
  output logic [DW-1:0] imem_wdata_o,
  output logic          core_rst_n_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  loader_state_e r_state, w_next_state;

  logic [AW-1:0] r_len, r_word_idx;
  logic          r_byte_ready, r_we, r_busy, r_done, r_err;
  logic          w_len_ok, w_accept, w_clear, w_load, w_err_set, w_last_byte;
  logic [DW-1:0] w_word;

  assign w_len_ok = (len_words_i != '0) && (len_words_i <= AW'(NO_OF_REGS));
  assign w_accept = r_byte_ready && byte_valid_i;
  assign w_clear  = w_load || (r_state == WRITE);

  word_packer #(.DW(DW)) u_word_packer (
    .i_clk       (clk_i),
    .i_rst_n     (rst_i),
    .i_accept    (w_accept),
    .i_clear     (w_clear),
    .i_byte      (byte_data_i),
    .o_word      (w_word),
    .o_last_byte (w_last_byte)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start_i) begin
          if (w_len_ok) begin
            w_next_state = RECV;
            w_load       = 1'b1;
          end else begin
            w_next_state = IDLE;
            w_err_set    = 1'b1;
          end
        end
      end
      RECV:    if (w_accept && w_last_byte) w_next_state = WRITE;
      WRITE:   w_next_state = ((r_word_idx + AW'(1)) == r_len) ? DONE : RECV;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_len        <= '0;
      r_word_idx   <= '0;
    end else begin
      r_byte_ready <= (w_next_state == RECV);
      r_we         <= (w_next_state == WRITE);
      r_busy       <= (w_next_state == RECV) || (w_next_state == WRITE);
      r_done       <= (w_next_state == DONE);
      if (w_load) begin
        r_len      <= len_words_i;
        r_word_idx <= '0;
        r_err      <= 1'b0;
      end else if (w_err_set) begin
        r_err      <= 1'b1;
      end else if (r_state == WRITE) begin
        r_word_idx <= r_word_idx + AW'(1);
      end
    end
  end

  assign byte_ready_o = r_byte_ready;
  assign imem_we_o    = r_we;
  assign imem_addr_o  = DW'({r_word_idx, 2'b00});
  assign imem_wdata_o = w_word;
  assign core_rst_n_o = r_done;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign err_o        = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: length-check vector table, scoreboard
// of expected memory writes, and hand sequences for multi-cycle corner cases.
module tb_prog_loader;

  localparam int DW         = 32;
  localparam int NO_OF_REGS = 256;
  localparam int AW         = 9;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [AW-1:0] len_words_i;
  logic          byte_valid_i;
  logic [7:0]    byte_data_i;
  logic          byte_ready_o, imem_we_o, core_rst_n_o, busy_o, done_o, err_o;
  logic [DW-1:0] imem_addr_o, imem_wdata_o;

  prog_loader dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .len_words_i  (len_words_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .core_rst_n_o (core_rst_n_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [AW-1:0] len;
    logic          exp_err;
  } vec_t;

  wr_t         sb[$];
  logic [31:0] pattern[NO_OF_REGS];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc_cnt  = 0;

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every write strobe must match the oldest expected write.
  always @(negedge clk_i) begin
    wr_t e;
    if (rst_i && imem_we_o) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(imem_we_o), 32'd0);
      end else begin
        e = sb.pop_front();
        check("wr_addr", imem_addr_o, e.addr);
        check("wr_data", imem_wdata_o, e.data);
      end
    end
  end

  task automatic fill_pattern(input int n);
    for (int i = 0; i < n; i++) pattern[i] = $urandom;
  endtask

  task automatic push_words(input int n);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = 32'(i * 4);
      e.data = pattern[i];
      sb.push_back(e);
    end
  endtask

  // Called one step after a rising edge; returns at the same phase.
  task automatic do_start(input logic [AW-1:0] len);
    start_i     = 1'b1;
    len_words_i = len;
    @(posedge clk_i); #1;
    start_i     = 1'b0;
  endtask

  task automatic stream(input int nbytes, input bit toggle, output int nlow);
    int idx = 0, cyc = 0, bad_rst = 0;
    nlow = 0;
    while (idx < nbytes && cyc < nbytes * 4 + 20) begin
      byte_valid_i = toggle ? (cyc % 2 == 0) : 1'b1;
      byte_data_i  = pattern[idx / 4][8 * (idx % 4) +: 8];
      @(negedge clk_i);
      if (!byte_ready_o) nlow++;
      if (core_rst_n_o)  bad_rst++;
      if (byte_ready_o && byte_valid_i) idx++;
      @(posedge clk_i); #1;
      cyc++;
    end
    byte_valid_i = 1'b0;
    check("stream_bytes_accepted", 32'(idx), 32'(nbytes));
    check("core_rst_low_during_load", 32'(bad_rst), 32'd0);
  endtask

  task automatic wait_done(output int at_cyc);
    bit seen = 1'b0;
    at_cyc = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (done_o) begin
        seen   = 1'b1;
        at_cyc = cyc_cnt;
        break;
      end
    end
    check("done_reached", 32'(seen), 32'd1);
    check("core_rst_released", 32'(core_rst_n_o), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    vec_t vecs[6];
    int   nlow, t_start, t_done;

    vecs[0] = '{len: 9'd0,   exp_err: 1'b1};
    vecs[1] = '{len: 9'd257, exp_err: 1'b1};
    vecs[2] = '{len: 9'd1,   exp_err: 1'b0};
    vecs[3] = '{len: 9'd511, exp_err: 1'b1};
    vecs[4] = '{len: 9'd3,   exp_err: 1'b0};
    vecs[5] = '{len: 9'd2,   exp_err: 1'b0};

    rst_i = 1'b0; start_i = 1'b0; len_words_i = '0;
    byte_valid_i = 1'b0; byte_data_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", 32'(byte_ready_o), 32'd0);
    check("rst_we", 32'(imem_we_o), 32'd0);
    check("rst_addr", imem_addr_o, 32'd0);
    check("rst_wdata", imem_wdata_o, 32'd0);
    check("rst_core_rst_n", 32'(core_rst_n_o), 32'd0);
    check("rst_busy_done_err", {29'd0, busy_o, done_o, err_o}, 32'd0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Length check table: illegal lengths flag err, legal ones load fully.
    for (int v = 0; v < 6; v++) begin
      do_start(vecs[v].len);
      if (vecs[v].exp_err) begin
        @(negedge clk_i);
        check("vec_err", 32'(err_o), 32'd1);
        check("vec_err_idle", {29'd0, busy_o, done_o, core_rst_n_o}, 32'd0);
        @(posedge clk_i); #1;
      end else begin
        check("vec_err_cleared", 32'(err_o), 32'd0);
        fill_pattern(int'(vecs[v].len));
        push_words(int'(vecs[v].len));
        stream(int'(vecs[v].len) * 4, 1'b0, nlow);
        wait_done(t_done);
      end
    end

    // Two words with valid held high: fixed bytes and done latency.
    pattern[0] = 32'h1234_5678;
    pattern[1] = 32'hDEAD_BEEF;
    push_words(2);
    do_start(9'd2);
    t_start = cyc_cnt;
    stream(8, 1'b0, nlow);
    check("len2_ready_low_cycles", 32'(nlow), 32'd1);
    wait_done(t_done);
    check("len2_done_latency", 32'(t_done - t_start), 32'd10);

    // One word with valid toggling; ready drops only for the write cycle.
    fill_pattern(1);
    push_words(1);
    do_start(9'd1);
    stream(4, 1'b1, nlow);
    check("toggle_ready_low_cycles", 32'(nlow), 32'd0);
    @(negedge clk_i);
    check("toggle_ready_in_write", 32'(byte_ready_o), 32'd0);
    check("toggle_we_in_write", 32'(imem_we_o), 32'd1);
    @(posedge clk_i); #1;
    wait_done(t_done);

    // Full memory: last write at 0x3FC, then DONE with no wrap.
    fill_pattern(NO_OF_REGS);
    push_words(NO_OF_REGS);
    do_start(9'd256);
    stream(NO_OF_REGS * 4, 1'b0, nlow);
    wait_done(t_done);

    // start_i held during RECV must not reload the length.
    fill_pattern(2);
    push_words(2);
    do_start(9'd2);
    start_i = 1'b1; len_words_i = 9'd5;
    repeat (3) begin @(posedge clk_i); #1; end
    start_i = 1'b0;
    stream(8, 1'b0, nlow);
    wait_done(t_done);

    // start_i in DONE begins a new load and pulls core reset low at once.
    fill_pattern(1);
    push_words(1);
    do_start(9'd1);
    @(negedge clk_i);
    check("restart_core_rst_n", 32'(core_rst_n_o), 32'd0);
    check("restart_busy", 32'(busy_o), 32'd1);
    check("restart_ready", 32'(byte_ready_o), 32'd1);
    @(posedge clk_i); #1;
    stream(4, 1'b0, nlow);
    wait_done(t_done);

    // Reset two bytes into word 3: words 0-2 written, partial word dropped.
    fill_pattern(4);
    push_words(3);
    do_start(9'd4);
    stream(14, 1'b0, nlow);
    #2 rst_i = 1'b0;
    #1;
    check("midrst_ready", 32'(byte_ready_o), 32'd0);
    check("midrst_we", 32'(imem_we_o), 32'd0);
    check("midrst_addr", imem_addr_o, 32'd0);
    check("midrst_wdata", imem_wdata_o, 32'd0);
    check("midrst_flags", {28'd0, core_rst_n_o, busy_o, done_o, err_o}, 32'd0);
    check("midrst_three_words", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("post_rst_idle", {29'd0, busy_o, done_o, imem_we_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
